// File: rtl/axis_mux_nx1.sv
// ---------------------------------------------------------------------------
// axis_mux_nx1
//
// N-to-1 AXI-Stream multiplexer with packet-level locking. One slave channel
// is granted at a packet boundary and keeps the grant until its tlast beat is
// accepted. The winner is chosen either by the external `select` input
// (ARB_MODE=0) or round-robin over valid channels (ARB_MODE=1). The master
// side is a single registered output stage, so the latency is one cycle and
// the throughput is one beat per cycle.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   s_axis_tdata   NUM_CH packed channels, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid  per-channel valid
//   s_axis_tlast   per-channel end of packet
//   s_axis_tready  per-channel ready (only the granted channel, only while locked)
//   select         requested channel, used when ARB_MODE=0
//   m_axis_tdata   output data register
//   m_axis_tvalid  output valid
//   m_axis_tready  downstream ready
//   m_axis_tlast   output end of packet
//   grant          channel most recently granted (held between packets)
//   active         high while a packet is locked
// ---------------------------------------------------------------------------
module axis_mux_nx1 #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int ARB_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  input  logic [NUM_CH-1:0]            s_axis_tlast,
  output logic [NUM_CH-1:0]            s_axis_tready,
  input  logic [SEL_WIDTH-1:0]         select,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [SEL_WIDTH-1:0]         grant,
  output logic                         active
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state;
  state_t                state_next;
  logic [SEL_WIDTH-1:0]  rr_last;

  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  out_free;
  logic                  accept;

  logic                  sel_hit;
  logic                  rr_hit;
  logic [SEL_WIDTH-1:0]  rr_pick;
  int                    rr_best;
  int                    rr_dist;
  logic                  arb_hit;
  logic [SEL_WIDTH-1:0]  arb_pick;

  assign active = (state == LOCKED);

  // The output register can take a new beat when it is empty or draining.
  assign out_free = ~m_axis_tvalid | m_axis_tready;
  assign accept   = (state == LOCKED) & g_valid & out_free;

  // Granted-channel view of the slave side.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment; a missing default on some path infers a latch.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == SEL_WIDTH'(i)) begin
        g_valid = s_axis_tvalid[i];
        g_last  = s_axis_tlast[i];
        g_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      s_axis_tready[i] = (state == LOCKED) && (grant == SEL_WIDTH'(i)) && out_free;
    end
  end

  // External select: an out-of-range select matches no channel, so no grant.
  always_comb begin
    sel_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (select == SEL_WIDTH'(i)) sel_hit = s_axis_tvalid[i];
    end
  end

  // Round-robin: rank each channel by its distance past the last grant
  // (the channel right after rr_last has distance 0) and take the nearest
  // valid one.
  always_comb begin
    rr_hit  = 1'b0;
    rr_pick = '0;
    rr_best = NUM_CH;
    rr_dist = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      rr_dist = (i + NUM_CH - 1 - int'(rr_last)) % NUM_CH;
      if (s_axis_tvalid[i] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        rr_pick = SEL_WIDTH'(i);
        rr_hit  = 1'b1;
      end
    end
  end

  always_comb begin
    arb_hit  = 1'b0;
    arb_pick = '0;
    if (ARB_MODE == 1) begin
      arb_hit  = rr_hit;
      arb_pick = rr_pick;
    end else begin
      arb_hit  = sel_hit;
      arb_pick = select;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arb_hit) state_next = LOCKED;
      LOCKED:  if (accept && g_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // rr_last resets to the highest channel so channel 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant   <= '0;
      rr_last <= SEL_WIDTH'(NUM_CH - 1);
    end else begin
      if (state == IDLE && arb_hit) grant <= arb_pick;
      if (accept && g_last)         rr_last <= grant;
    end
  end

  // Output stage: data and last only change on an accepted beat, so they
  // hold while stalled or empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= g_last;
      m_axis_tdata  <= g_data;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_mux_nx1.sv
// ---------------------------------------------------------------------------
// tb_axis_mux_nx1
//
// Three instances: external select with 4 channels, external select with
// 3 channels (out-of-range select), and round-robin with 4 channels.
// Directed sequences cover locking, latency, reset and backpressure on the
// select instance; the round-robin instance runs against a packet-level
// model that predicts the grant order and the output beat stream.
// ---------------------------------------------------------------------------
module tb_axis_mux_nx1;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- select instance, 4 channels ----
  logic [31:0] s_data_s;
  logic [3:0]  s_valid_s, s_last_s, s_ready_s;
  logic [1:0]  sel_s, grant_s;
  logic [7:0]  m_data_s;
  logic        m_valid_s, m_ready_s, m_last_s, active_s;

  axis_mux_nx1 #(.DATA_WIDTH(8), .NUM_CH(4), .SEL_WIDTH(2), .ARB_MODE(0)) dut_s (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_data_s), .s_axis_tvalid(s_valid_s), .s_axis_tlast(s_last_s),
    .s_axis_tready(s_ready_s), .select(sel_s),
    .m_axis_tdata(m_data_s), .m_axis_tvalid(m_valid_s), .m_axis_tready(m_ready_s),
    .m_axis_tlast(m_last_s), .grant(grant_s), .active(active_s)
  );

  // ---- select instance, 3 channels ----
  logic [23:0] s_data_3;
  logic [2:0]  s_valid_3, s_last_3, s_ready_3;
  logic [1:0]  sel_3, grant_3;
  logic [7:0]  m_data_3;
  logic        m_valid_3, m_ready_3, m_last_3, active_3;

  axis_mux_nx1 #(.DATA_WIDTH(8), .NUM_CH(3), .SEL_WIDTH(2), .ARB_MODE(0)) dut_3 (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_data_3), .s_axis_tvalid(s_valid_3), .s_axis_tlast(s_last_3),
    .s_axis_tready(s_ready_3), .select(sel_3),
    .m_axis_tdata(m_data_3), .m_axis_tvalid(m_valid_3), .m_axis_tready(m_ready_3),
    .m_axis_tlast(m_last_3), .grant(grant_3), .active(active_3)
  );

  // ---- round-robin instance, 4 channels ----
  logic [31:0] s_data_r;
  logic [3:0]  s_valid_r, s_last_r, s_ready_r;
  logic [1:0]  sel_r, grant_r;
  logic [7:0]  m_data_r;
  logic        m_valid_r, m_ready_r, m_last_r, active_r;

  axis_mux_nx1 #(.DATA_WIDTH(8), .NUM_CH(4), .SEL_WIDTH(2), .ARB_MODE(1)) dut_r (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_data_r), .s_axis_tvalid(s_valid_r), .s_axis_tlast(s_last_r),
    .s_axis_tready(s_ready_r), .select(sel_r),
    .m_axis_tdata(m_data_r), .m_axis_tvalid(m_valid_r), .m_axis_tready(m_ready_r),
    .m_axis_tlast(m_last_r), .grant(grant_r), .active(active_r)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch_s(input int c, input logic v, input logic [7:0] d, input logic l);
    s_valid_s[c]        = v;
    s_data_s[c*8 +: 8]  = d;
    s_last_s[c]         = l;
  endtask

  // ---- round-robin stimulus and model state ----
  // Beats are {last, data}; each channel queue is a sequence of whole packets.
  logic [8:0] bq [4][$];
  logic [8:0] mq [4][$];
  logic [8:0] exp_beats [$];
  logic [1:0] exp_grants [$];
  int         out_cyc [$];
  bit         in_pkt [4];
  int         mdl_last = 3;
  int         cyc_r = 0;
  int         idle_cnt = 0;
  int         pkts_started = 0;
  logic       prev_stall_r = 1'b0;
  logic [7:0] prev_data_r = '0;
  logic       prev_last_r = 1'b0;
  logic       prev_active_r = 1'b0;
  bit         rr_rand_ready = 1'b0;
  bit         rr_gap = 1'b0;

  // Packet-level round-robin: serve channels in rotation after the last
  // served one, skipping channels with nothing pending, whole packet at a time.
  task automatic rr_model();
    int pick;
    int c;
    logic [8:0] b;
    for (int k = 0; k < 4; k++) mq[k] = bq[k];
    do begin
      pick = -1;
      for (int k = 1; k <= 4; k++) begin
        c = (mdl_last + k) % 4;
        if (pick < 0 && mq[c].size() > 0) pick = c;
      end
      if (pick >= 0) begin
        exp_grants.push_back(2'(pick));
        do begin
          b = mq[pick].pop_front();
          exp_beats.push_back(b);
        end while (!b[8]);
        mdl_last = pick;
      end
    end while (pick >= 0);
  endtask

  task automatic rr_drive(input logic [3:0] fire);
    logic [8:0] b;
    for (int c = 0; c < 4; c++) begin
      if (fire[c]) begin
        b = bq[c].pop_front();
        in_pkt[c] = !b[8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (bq[c].size() > 0) begin
        // Valid may only drop mid-packet so packet starts stay continuous.
        s_valid_r[c]       = !(rr_gap && in_pkt[c] && ($urandom_range(0, 3) == 0));
        s_data_r[c*8 +: 8] = bq[c][0][7:0];
        s_last_r[c]        = bq[c][0][8];
      end else begin
        s_valid_r[c] = 1'b0;
        s_last_r[c]  = 1'b0;
      end
    end
    m_ready_r = rr_rand_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
  endtask

  task automatic rr_cycle();
    logic [3:0] fire;
    logic [3:0] exp_rdy;
    logic [8:0] b;
    @(negedge clk);
    cyc_r++;
    if (prev_stall_r) begin
      check("rr_hold_valid", m_valid_r, 1);
      check("rr_hold_data", m_data_r, prev_data_r);
      check("rr_hold_last", m_last_r, prev_last_r);
    end
    if (m_valid_r && m_ready_r) begin
      if (exp_beats.size() == 0) check("rr_extra_beat", 1, 0);
      else begin
        b = exp_beats.pop_front();
        check("rr_data", m_data_r, b[7:0]);
        check("rr_last", m_last_r, b[8]);
        out_cyc.push_back(cyc_r);
      end
    end
    prev_stall_r = m_valid_r && !m_ready_r;
    prev_data_r  = m_data_r;
    prev_last_r  = m_last_r;

    if (active_r && !prev_active_r) begin
      if (exp_grants.size() == 0) check("rr_extra_grant", 1, 0);
      else begin
        check("rr_grant", grant_r, exp_grants[0]);
        if (pkts_started > 0) check("rr_idle_gap", idle_cnt, 1);
      end
      pkts_started++;
    end
    idle_cnt      = active_r ? 0 : idle_cnt + 1;
    prev_active_r = active_r;

    exp_rdy = '0;
    if (active_r && exp_grants.size() > 0 && (!m_valid_r || m_ready_r)) exp_rdy[exp_grants[0]] = 1'b1;
    check("rr_tready", s_ready_r, exp_rdy);

    fire = s_valid_r & s_ready_r;
    if (exp_grants.size() > 0 && fire[exp_grants[0]] && s_last_r[exp_grants[0]])
      void'(exp_grants.pop_front());
    tick();
    rr_drive(fire);
  endtask

  task automatic rr_phase(input bit rand_ready, input bit gap, input int budget);
    rr_rand_ready = rand_ready;
    rr_gap        = gap;
    exp_beats.delete();
    exp_grants.delete();
    out_cyc.delete();
    rr_model();
    pkts_started = 0;
    rr_drive(4'b0000);
    for (int i = 0; i < budget && exp_beats.size() > 0; i++) rr_cycle();
    check("rr_beats_left", exp_beats.size(), 0);
    check("rr_pkts_left", exp_grants.size(), 0);
  endtask

  // ---- main sequence ----
  initial begin
    int   bp_idx, bp_out;
    logic bp_fire, prev_stall;
    logic [7:0] prev_data;
    int   npk, len;

    reset = 1'b1;
    s_data_s = '0; s_valid_s = '0; s_last_s = '0; sel_s = '0; m_ready_s = 1'b1;
    s_data_3 = '0; s_valid_3 = '0; s_last_3 = '0; sel_3 = '0; m_ready_3 = 1'b1;
    s_data_r = '0; s_valid_r = '0; s_last_r = '0; sel_r = '0; m_ready_r = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_mvalid", m_valid_s, 0);
    check("rst_mlast", m_last_s, 0);
    check("rst_mdata", m_data_s, 0);
    check("rst_trdy", s_ready_s, 0);
    check("rst_active", active_s, 0);
    check("rst_grant", grant_s, 0);
    check("rst_rr_active", active_r, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst2_mvalid", m_valid_s, 0);
    check("rst2_grant", grant_s, 0);
    tick();
    reset = 1'b0;

    // External select, packet lock
    sel_s = 2'd2;
    set_ch_s(2, 1'b1, 8'h01, 1'b0);
    @(negedge clk);
    check("idle_active", active_s, 0);
    check("idle_trdy", s_ready_s, 4'b0000);
    tick();
    @(negedge clk);
    check("lock_active", active_s, 1);
    check("lock_grant", grant_s, 2);
    check("lock_trdy", s_ready_s, 4'b0100);
    check("lock_mvalid", m_valid_s, 0);
    tick();
    sel_s = 2'd1;
    set_ch_s(2, 1'b1, 8'h02, 1'b0);
    set_ch_s(1, 1'b1, 8'h55, 1'b1);
    @(negedge clk);
    check("b1_valid", m_valid_s, 1);
    check("b1_data", m_data_s, 8'h01);
    check("b1_last", m_last_s, 0);
    check("b1_grant", grant_s, 2);
    check("b1_trdy", s_ready_s, 4'b0100);
    tick();
    set_ch_s(2, 1'b1, 8'h03, 1'b1);
    @(negedge clk);
    check("b2_valid", m_valid_s, 1);
    check("b2_data", m_data_s, 8'h02);
    check("b2_grant", grant_s, 2);
    tick();
    set_ch_s(2, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("b3_data", m_data_s, 8'h03);
    check("b3_last", m_last_s, 1);
    check("gap_active", active_s, 0);
    check("gap_grant", grant_s, 2);
    check("gap_trdy", s_ready_s, 4'b0000);
    tick();
    @(negedge clk);
    check("relock_grant", grant_s, 1);
    check("relock_active", active_s, 1);
    check("relock_mvalid", m_valid_s, 0);
    check("relock_trdy", s_ready_s, 4'b0010);
    tick();
    set_ch_s(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("sb_valid", m_valid_s, 1);
    check("sb_data", m_data_s, 8'h55);
    check("sb_active", active_s, 0);
    tick();
    @(negedge clk);
    check("drain_valid", m_valid_s, 0);
    check("drain_hold_data", m_data_s, 8'h55);
    check("drain_hold_last", m_last_s, 1);
    tick();

    // Reset during the third beat of a packet
    sel_s = 2'd3;
    set_ch_s(3, 1'b1, 8'hC0, 1'b0);
    tick();
    tick();
    set_ch_s(3, 1'b1, 8'hC1, 1'b0);
    tick();
    set_ch_s(3, 1'b1, 8'hC2, 1'b0);
    check("pre_rst_active", active_s, 1);
    check("pre_rst_grant", grant_s, 3);
    check("pre_rst_mvalid", m_valid_s, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_grant", grant_s, 0);
    check("mid_rst_active", active_s, 0);
    check("mid_rst_mvalid", m_valid_s, 0);
    check("mid_rst_mdata", m_data_s, 0);
    check("mid_rst_trdy", s_ready_s, 0);
    set_ch_s(3, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_active", active_s, 0);
    check("post_rst_grant", grant_s, 0);
    check("post_rst_mvalid", m_valid_s, 0);
    tick();

    // Backpressure: 4-beat packet, m_tready alternating 1,0,1,0
    sel_s = 2'd0;
    bp_idx = 0; bp_out = 0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 40 && bp_out < 4; cyc++) begin
      if (bp_idx < 4) set_ch_s(0, 1'b1, 8'(8'h41 + bp_idx), bp_idx == 3);
      else            set_ch_s(0, 1'b0, 8'h00, 1'b0);
      m_ready_s = (cyc % 2 == 0);
      @(negedge clk);
      if (prev_stall) begin
        check("bp_hold_valid", m_valid_s, 1);
        check("bp_hold_data", m_data_s, prev_data);
      end
      if (m_valid_s && !m_ready_s) check("bp_trdy_low", s_ready_s, 4'b0000);
      if (m_valid_s && m_ready_s) begin
        check("bp_data", m_data_s, 8'h41 + bp_out);
        check("bp_last", m_last_s, bp_out == 3);
        bp_out++;
      end
      prev_stall = m_valid_s && !m_ready_s;
      prev_data  = m_data_s;
      bp_fire    = s_valid_s[0] & s_ready_s[0];
      tick();
      if (bp_fire) bp_idx++;
    end
    check("bp_count", bp_out, 4);
    set_ch_s(0, 1'b0, 8'h00, 1'b0);
    m_ready_s = 1'b1;

    // Out-of-range select with 3 channels
    sel_3 = 2'd3; s_valid_3 = 3'b111; s_last_3 = 3'b111; s_data_3 = 24'h332211;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("n3_active", active_3, 0);
      check("n3_trdy", s_ready_3, 3'b000);
      check("n3_mvalid", m_valid_3, 0);
      tick();
    end
    sel_3 = 2'd2;
    tick();
    @(negedge clk);
    check("n3_ok_active", active_3, 1);
    check("n3_ok_grant", grant_3, 2);
    check("n3_ok_trdy", s_ready_3, 3'b100);
    tick();
    s_valid_3 = 3'b000;

    // Round-robin fairness: channels 0, 1, 3 with two 2-beat packets each
    bq[0] = {9'h010, 9'h111, 9'h010, 9'h111};
    bq[1] = {9'h020, 9'h121, 9'h020, 9'h121};
    bq[3] = {9'h030, 9'h131, 9'h030, 9'h131};
    rr_phase(1'b0, 1'b0, 200);
    check("fair_last_grant", grant_r, 3);

    // Single-beat packets back to back
    bq[1] = {9'h1AA};
    bq[2] = {9'h1BB};
    rr_phase(1'b0, 1'b0, 100);
    check("sb_out_count", out_cyc.size(), 2);
    if (out_cyc.size() == 2) check("sb_spacing", out_cyc[1] - out_cyc[0], 2);

    // Random packets, random backpressure and mid-packet valid gaps
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 4; c++) begin
        npk = $urandom_range(0, 3);
        for (int k = 0; k < npk; k++) begin
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++) bq[c].push_back({j == len - 1, 8'($urandom)});
        end
      end
      rr_phase(1'b1, 1'b1, 3000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_mux_nx1.md
# axis_mux_nx1

Parametrised N-to-1 AXI-Stream multiplexer with packet-level locking, the successor to the 2:1 select-driven mux in the streaming datapath. Routes one of `NUM_CH` slave streams to a single master stream through a registered output stage. A channel is granted only at a packet boundary and is held until its `tlast` beat is accepted. Arbitration is either externally selected or round-robin, set by parameter.

## Interface
Parameters:
- `DATA_WIDTH`, 8: tdata width per channel.
- `NUM_CH`, 4: number of slave channels; must be 2 or more.
- `SEL_WIDTH`, 2: width of `select` and `grant`; must be at least clog2(`NUM_CH`).
- `ARB_MODE`, 0: 0 means external `select`; 1 means round-robin over valid channels.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `s_axis_tdata`, in, NUM_CH*DATA_WIDTH: channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_tvalid`, in, NUM_CH: per-channel valid.
- `s_axis_tlast`, in, NUM_CH: per-channel end of packet.
- `s_axis_tready`, out, NUM_CH: per-channel ready.
- `select`, in, SEL_WIDTH: requested channel; used only when ARB_MODE=0.
- `m_axis_tdata`, out, DATA_WIDTH: output data.
- `m_axis_tvalid`, out, 1: output valid.
- `m_axis_tready`, in, 1: downstream ready.
- `m_axis_tlast`, out, 1: output end of packet.
- `grant`, out, SEL_WIDTH: currently locked channel.
- `active`, out, 1: high while a packet is locked.

## Operation
- The FSM has two states: IDLE and LOCKED.
- In IDLE, arbitration is evaluated every cycle:
  - ARB_MODE=0: the candidate is `select`. A grant is issued only if `select` < NUM_CH and `s_axis_tvalid[select]`=1.
  - ARB_MODE=1: search starts at the channel after the last granted channel, wrapping at NUM_CH-1 to 0. The first channel with tvalid=1 wins.
  - On a win: `grant` is loaded with the winner, `active` goes to 1, and the FSM moves to LOCKED at the next edge.
  - With no winner, the FSM stays in IDLE.
- In LOCKED:
  - `s_axis_tready[grant]` = (~`m_axis_tvalid`) | `m_axis_tready`. Every other channel's tready is 0.
  - A beat is accepted when both valid and tready are high on the granted channel. Its tdata and tlast load into the output register, and `m_axis_tvalid` is set to 1.
  - If the output register drains (`m_axis_tready`=1) with no new beat accepted, `m_axis_tvalid` goes to 0.
  - Accepting a beat with tlast=1 clears `active` and returns the FSM to IDLE at the same edge. The round-robin pointer records `grant` at that edge.
- Changes to `select` and tvalid on other channels are ignored while LOCKED. The grant never changes mid-packet.
- If the granted channel drops tvalid mid-packet, the FSM stays LOCKED and waits indefinitely.
- In IDLE, every `s_axis_tready` bit is 0. A pending output beat still drains normally.
- `m_axis_tdata` and `m_axis_tlast` hold their last value while `m_axis_tvalid`=0 or while the output is stalled.

## Timing
- Reset values:
  - `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `s_axis_tready`, `active`: all 0.
  - `grant`: 0.
  - FSM: IDLE.
  - Round-robin last grant: NUM_CH-1, so channel 0 has first priority after reset.
- Reset asserted mid-packet aborts the packet: the outputs above clear immediately (asynchronously) and the partial packet is not completed.
- Cycle timing for a packet:
  - Cycle n: tvalid is high on the winning channel while IDLE.
  - Cycle n+1: LOCKED, tready high, first beat accepted.
  - Cycle n+2: `m_axis_tvalid`=1.
- Latency is 1 cycle from beat acceptance to output.
- Throughput inside a packet is 1 beat/cycle with `m_axis_tready` held high.
- There is exactly 1 idle arbitration cycle between consecutive packets.
- A single-beat packet (tlast on the first beat) locks for exactly 1 cycle.
- Backpressure: when `m_axis_tvalid`=1 and `m_axis_tready`=0, the output register is stable and the granted channel's tready is 0 in the same cycle.

## Test plan
- **Reset values, mid-packet reset.**
  - Stimulus: ARB_MODE=0, NUM_CH=4, DATA_WIDTH=8. Assert `reset` for 2 cycles; then assert `reset` again during the third beat of a packet.
  - Required: all outputs 0 during reset, and after the mid-packet reset `grant`=0, `active`=0, `m_axis_tvalid`=0.
- **External select, packet lock.**
  - Stimulus: `select`=2; channel 2 sends 0x01,0x02,0x03 with tlast on 0x03; `m_axis_tready`=1. Switch `select` to 1 after the first beat.
  - Required: the output carries 0x01,0x02,0x03 on consecutive cycles from n+2 with `m_axis_tlast` on 0x03. `grant` stays 2 until the tlast beat, then becomes 1 after one idle cycle.
- **Invalid select.**
  - Stimulus: `select`=3 with NUM_CH=3 while all channels are valid.
  - Required: no grant, `active`=0, all tready 0.
- **Round-robin fairness.**
  - Stimulus: ARB_MODE=1; channels 0, 1 and 3 continuously send 2-beat packets tagged 0x10, 0x20 and 0x30.
  - Required: grant order is 0, 1, 3, 0, 1, 3, with one idle cycle between packets.
- **Backpressure.**
  - Stimulus: during a 4-beat packet, `m_axis_tready` alternates 1,0,1,0.
  - Required: no beat is lost or duplicated, output data is stable while stalled, and granted tready is low in the stall cycles.
- **Single-beat packets back to back.**
  - Stimulus: ARB_MODE=1; channels 1 and 2 each send one beat with tlast, 0xAA and 0xBB.
  - Required: the output is 0xAA then 0xBB, both with tlast, spaced 2 cycles apart.
